// File: rtl/firebird7_in_gate1_ijtag_pkg.sv
// Shared definitions for the gate1 IJTAG test data registers.
//
// Contents:
//   TDR_WIDTH  - data width of the gate1 mux control register
//   SEL_BIT    - shift register index of the mux select bit
//   CHG_BIT    - shift register index of the change flag / clear bit
//   sr_len_of  - shift register length for a given data width
//   upd_t      - layout of the update register (select + data)
package firebird7_in_gate1_ijtag_pkg;

    localparam int TDR_WIDTH = 3;
    localparam int SEL_BIT   = TDR_WIDTH;
    localparam int CHG_BIT   = TDR_WIDTH + 1;

    // The shift register carries the data field, the select bit and the
    // change flag / clear bit.
    function automatic int sr_len_of(input int w);
        return w + 2;
    endfunction

    typedef struct packed {
        logic                 sel;
        logic [TDR_WIDTH-1:0] data;
    } upd_t;

endpackage

// File: rtl/firebird7_in_gate1_tessent_chg_detect.sv
// Sticky change detector for the functional data observed by the gate1 TDR.
//
// Ports:
//   ijtag_tck          - test clock, rising edge
//   ijtag_reset        - asynchronous active-low reset
//   functional_data_in - quasi-static functional value being watched
//   clr                - write-1-to-clear request from the TDR update stage
//   chg                - sticky flag, set on any toggle of functional_data_in
module firebird7_in_gate1_tessent_chg_detect #(
    parameter int WIDTH = 3
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic [WIDTH-1:0] functional_data_in,
    input  logic             clr,
    output logic             chg
);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic             armed_q, armed_d;
    logic             chg_q, chg_d;

    // prev is only meaningful after the first edge out of reset, so armed
    // holds off detection for that edge. The set is evaluated after the
    // clear so a toggle coinciding with a clear is never lost.
    always_comb begin
        prev_d  = functional_data_in;
        armed_d = 1'b1;
        chg_d   = chg_q;
        if (clr) begin
            chg_d = 1'b0;
        end
        if (armed_q && (functional_data_in != prev_q)) begin
            chg_d = 1'b1;
        end
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            prev_q  <= '0;
            armed_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
            chg_q   <= chg_d;
        end
    end

    assign chg = chg_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_ctl_obs_w3.sv
// IJTAG test data register controlling the gate1 data mux and observing its
// functional input.
//
// Ports:
//   ijtag_tck, ijtag_reset   - test clock (rising edge), async active-low reset
//   ijtag_sel                - TDR is on the active scan path
//   ijtag_ce/se/ue           - capture / shift / update enables
//   ijtag_si, ijtag_so       - scan in / scan out (LSB first)
//   functional_data_in       - functional value presented to the mux
//   ijtag_select             - mux select from the update register
//   ijtag_data_out           - mux ijtag data from the update register
//   change_flag              - sticky functional-toggle status
//
// Shift register layout: [CHG_BIT] change flag / clear, [SEL_BIT] select,
// [WIDTH-1:0] data.
module firebird7_in_gate1_tessent_tdr_ctl_obs_w3
    import firebird7_in_gate1_ijtag_pkg::*;
#(
    parameter int WIDTH = TDR_WIDTH
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             change_flag
);

    localparam int SR_LEN = sr_len_of(WIDTH);

    logic [SR_LEN-1:0] sr_q, sr_d;
    upd_t              upd_q, upd_d;
    logic              chg;
    logic              chg_clr;

    // One operation per cycle with capture > shift > update. A deselected
    // TDR holds its scan and update state; change detection runs regardless.
    always_comb begin
        sr_d    = sr_q;
        upd_d   = upd_q;
        chg_clr = 1'b0;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr_d = {chg, upd_q.sel, functional_data_in};
            end else if (ijtag_se) begin
                sr_d = {ijtag_si, sr_q[SR_LEN-1:1]};
            end else if (ijtag_ue) begin
                upd_d   = upd_t'(sr_q[SEL_BIT:0]);
                chg_clr = sr_q[CHG_BIT];
            end
        end
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sr_q  <= '0;
            upd_q <= '0;
        end else begin
            sr_q  <= sr_d;
            upd_q <= upd_d;
        end
    end

    firebird7_in_gate1_tessent_chg_detect #(
        .WIDTH(WIDTH)
    ) u_chg_detect (
        .ijtag_tck          (ijtag_tck),
        .ijtag_reset        (ijtag_reset),
        .functional_data_in (functional_data_in),
        .clr                (chg_clr),
        .chg                (chg)
    );

    assign ijtag_so       = sr_q[0];
    assign ijtag_select   = upd_q.sel;
    assign ijtag_data_out = upd_q.data;
    assign change_flag    = chg;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_ctl_obs_w3.sv
// Directed, table-driven bench for the gate1 control/observe TDR.
module tb_firebird7_in_gate1_tessent_tdr_ctl_obs_w3;

    localparam int NVEC = 25;

    logic       ijtag_tck;
    logic       ijtag_reset;
    logic       ijtag_sel;
    logic       ijtag_ce;
    logic       ijtag_se;
    logic       ijtag_ue;
    logic       ijtag_si;
    logic       ijtag_so;
    logic [2:0] functional_data_in;
    logic       ijtag_select;
    logic [2:0] ijtag_data_out;
    logic       change_flag;

    int checks_total;
    int checks_passed;

    typedef struct {
        logic       sel, ce, se, ue, si;
        logic [2:0] fdi;
        logic       exp_so;
        logic       exp_select;
        logic [2:0] exp_data;
        logic       exp_chg;
    } vec_t;

    vec_t vecs [NVEC];

    firebird7_in_gate1_tessent_tdr_ctl_obs_w3 dut (
        .ijtag_tck          (ijtag_tck),
        .ijtag_reset        (ijtag_reset),
        .ijtag_sel          (ijtag_sel),
        .ijtag_ce           (ijtag_ce),
        .ijtag_se           (ijtag_se),
        .ijtag_ue           (ijtag_ue),
        .ijtag_si           (ijtag_si),
        .ijtag_so           (ijtag_so),
        .functional_data_in (functional_data_in),
        .ijtag_select       (ijtag_select),
        .ijtag_data_out     (ijtag_data_out),
        .change_flag        (change_flag)
    );

    // Free-running test clock, 10 time-unit period.
    initial begin
        ijtag_tck = 1'b0;
        forever #5 ijtag_tck = ~ijtag_tck;
    end

    function automatic vec_t mk(input logic sel, input logic ce, input logic se,
                                input logic ue, input logic si, input logic [2:0] fdi,
                                input logic so, input logic s, input logic [2:0] d,
                                input logic c);
        vec_t v;
        v.sel = sel; v.ce = ce; v.se = se; v.ue = ue; v.si = si; v.fdi = fdi;
        v.exp_so = so; v.exp_select = s; v.exp_data = d; v.exp_chg = c;
        return v;
    endfunction

    // Advance one edge and land 1 unit after it, away from the active edge.
    task automatic tick();
        @(posedge ijtag_tck);
        #1;
    endtask

    task automatic applyStimulus(input logic sel, input logic ce, input logic se,
                                 input logic ue, input logic si, input logic [2:0] fdi);
        ijtag_sel          = sel;
        ijtag_ce           = ce;
        ijtag_se           = se;
        ijtag_ue           = ue;
        ijtag_si           = si;
        functional_data_in = fdi;
    endtask

    task automatic checkVal(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic so, input logic s,
                               input logic [2:0] d, input logic c);
        checkVal({tag, " so"},     {3'b000, ijtag_so},       {3'b000, so});
        checkVal({tag, " select"}, {3'b000, ijtag_select},   {3'b000, s});
        checkVal({tag, " data"},   {1'b0, ijtag_data_out},   {1'b0, d});
        checkVal({tag, " chg"},    {3'b000, change_flag},    {3'b000, c});
    endtask

    initial begin
        logic [4:0] pattern;
        checks_total  = 0;
        checks_passed = 0;

        //             sel ce se ue si fdi      so s  data    chg
        vecs[0]  = mk(1, 0, 1, 0, 1, 3'b000,  0, 0, 3'b000, 0);
        vecs[1]  = mk(1, 0, 1, 0, 0, 3'b000,  0, 0, 3'b000, 0);
        vecs[2]  = mk(1, 0, 1, 0, 1, 3'b000,  0, 0, 3'b000, 0);
        vecs[3]  = mk(1, 0, 1, 0, 1, 3'b000,  0, 0, 3'b000, 0);
        vecs[4]  = mk(1, 0, 1, 0, 0, 3'b000,  1, 0, 3'b000, 0);
        vecs[5]  = mk(1, 0, 0, 1, 0, 3'b000,  1, 1, 3'b101, 0);
        vecs[6]  = mk(1, 0, 0, 0, 0, 3'b110,  1, 1, 3'b101, 1);
        vecs[7]  = mk(1, 1, 0, 0, 0, 3'b110,  0, 1, 3'b101, 1);
        vecs[8]  = mk(1, 0, 1, 0, 0, 3'b110,  1, 1, 3'b101, 1);
        vecs[9]  = mk(1, 0, 1, 0, 0, 3'b110,  1, 1, 3'b101, 1);
        vecs[10] = mk(1, 0, 1, 0, 0, 3'b110,  1, 1, 3'b101, 1);
        vecs[11] = mk(1, 0, 1, 0, 0, 3'b110,  1, 1, 3'b101, 1);
        vecs[12] = mk(1, 0, 0, 1, 0, 3'b110,  1, 0, 3'b001, 1);
        vecs[13] = mk(1, 0, 1, 0, 1, 3'b110,  0, 0, 3'b001, 1);
        vecs[14] = mk(1, 0, 0, 1, 0, 3'b110,  0, 0, 3'b000, 0);
        vecs[15] = mk(1, 0, 0, 0, 0, 3'b010,  0, 0, 3'b000, 1);
        vecs[16] = mk(1, 0, 0, 1, 0, 3'b010,  0, 0, 3'b000, 0);
        vecs[17] = mk(1, 0, 0, 0, 0, 3'b011,  0, 0, 3'b000, 1);
        vecs[18] = mk(1, 0, 0, 1, 0, 3'b010,  0, 0, 3'b000, 1);
        vecs[19] = mk(1, 0, 0, 1, 0, 3'b010,  0, 0, 3'b000, 0);
        vecs[20] = mk(1, 1, 1, 1, 0, 3'b010,  0, 0, 3'b000, 0);
        vecs[21] = mk(1, 0, 1, 0, 0, 3'b010,  1, 0, 3'b000, 0);
        vecs[22] = mk(0, 1, 1, 1, 1, 3'b010,  1, 0, 3'b000, 0);
        vecs[23] = mk(1, 1, 1, 1, 1, 3'b010,  0, 0, 3'b000, 0);
        vecs[24] = mk(0, 0, 0, 0, 0, 3'b000,  0, 0, 3'b000, 1);

        // Reset state.
        applyStimulus(0, 0, 0, 0, 0, 3'b000);
        ijtag_reset = 1'b0;
        tick();
        tick();
        checkOutput("reset", 0, 0, 3'b000, 0);
        ijtag_reset = 1'b1;

        // Directed table: shift/update, capture readout, sticky flag, priority.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].ce, vecs[i].se, vecs[i].ue,
                          vecs[i].si, vecs[i].fdi);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_so, vecs[i].exp_select,
                        vecs[i].exp_data, vecs[i].exp_chg);
        end

        // Load upd = 4'b1101 with the flag still set, then reset asynchronously
        // between edges.
        pattern = 5'b01101;
        for (int b = 0; b < 5; b++) begin
            applyStimulus(1, 0, 1, 0, pattern[b], 3'b000);
            tick();
        end
        applyStimulus(1, 0, 0, 1, 0, 3'b000);
        tick();
        checkOutput("preload", 1, 1, 3'b101, 1);
        applyStimulus(1, 0, 1, 0, 1, 3'b000);
        #2;
        ijtag_reset = 1'b0;
        #1;
        checkOutput("async_reset", 0, 0, 3'b000, 0);
        tick();
        checkOutput("reset_hold", 0, 0, 3'b000, 0);

        // First edge after reset seeds prev without flagging a change.
        applyStimulus(0, 0, 0, 0, 0, 3'b011);
        ijtag_reset = 1'b1;
        tick();
        tick();
        checkOutput("armed_suppress", 0, 0, 3'b000, 0);
        applyStimulus(0, 0, 0, 0, 0, 3'b010);
        tick();
        checkOutput("armed_detect", 0, 0, 3'b000, 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
